// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges two byte sources onto a single serial transmitter:
//     - MIDI bytes, buffered in a FIFO_DEPTH-entry FIFO (order preserved,
//       bytes arriving while full are dropped and flagged sticky)
//     - diagnostic/host bytes, through a one-entry holding register with a
//       valid/ready handshake
//   When both sources are pending they alternate, round-robin. After reset
//   MIDI wins first.
//   An issue runs IDLE -> ISSUE -> HOLD -> WAIT. HOLD covers the one-cycle
//   latency before the transmitter raises tx_busy. WAIT returns to IDLE on
//   the first cycle with tx_busy low.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   midi_byte/valid      MIDI input; valid is a one-cycle pulse
//   diag_byte/valid      diag input; accepted when diag_valid & diag_ready
//   diag_ready           diag holding register is empty
//   tx_data/new_tx_data  byte to transmitter plus its one-cycle strobe
//   tx_busy, tx_block    transmitter busy / receiver buffer full
//   midi_count           FIFO occupancy
//   midi_overflow        sticky; a MIDI byte was dropped
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    midi_byte,
    input  logic                          midi_valid,
    input  logic [7:0]                    diag_byte,
    input  logic                          diag_valid,
    output logic                          diag_ready,
    output logic [7:0]                    tx_data,
    output logic                          new_tx_data,
    input  logic                          tx_busy,
    input  logic                          tx_block,
    output logic [$clog2(FIFO_DEPTH):0]   midi_count,
    output logic                          midi_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic G_MIDI = 1'b0;
    localparam logic G_DIAG = 1'b1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic          grant, last_grant;
    logic [7:0]    diag_reg;
    logic          diag_full;

    logic midi_pend, fifo_full, pop, push, diag_acc, diag_clr, start, next_grant;

    always_comb begin
        midi_pend = (count != '0);
        fifo_full = (count == C_FULL);
        pop       = (state == S_ISSUE) && (grant == G_MIDI);
        diag_clr  = (state == S_ISSUE) && (grant == G_DIAG);
        // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
        push      = midi_valid && (!fifo_full || pop);
        diag_acc  = diag_valid && !diag_full;
        start     = (state == S_IDLE) && !tx_busy && !tx_block && (midi_pend || diag_full);
        if (midi_pend && diag_full) next_grant = ~last_grant;
        else if (midi_pend)         next_grant = G_MIDI;
        else                        next_grant = G_DIAG;
    end

    assign diag_ready = !diag_full;
    assign midi_count = count;

    // Storage has no reset: occupancy lives in count and the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= midi_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            midi_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + A_ONE;
            if (pop)  rd_ptr <= rd_ptr + A_ONE;
            case ({push, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
            if (midi_valid && !push) midi_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_full <= 1'b0;
            diag_reg  <= 8'h00;
        end else if (diag_acc) begin
            diag_full <= 1'b1;
            diag_reg  <= diag_byte;
        end else if (diag_clr) begin
            diag_full <= 1'b0;
        end
    end

    // tx_data is loaded on entry to ISSUE and then left alone, so it holds
    // the last issued byte until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= G_MIDI;
            last_grant  <= G_DIAG;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state       <= S_ISSUE;
                    grant       <= next_grant;
                    tx_data     <= (next_grant == G_MIDI) ? fifo_mem[rd_ptr] : diag_reg;
                    new_tx_data <= 1'b1;
                end
                S_ISSUE: begin
                    last_grant <= grant;
                    state      <= S_HOLD;
                end
                S_HOLD:  state <= S_WAIT;
                default: if (!tx_busy) state <= S_IDLE;
            endcase
        end
    end
endmodule
